fp_div_sqrt_lane: RTL
=====================

# fp_div_sqrt_lane

Iterative FP32 divide / square-root unit for one FP issue lane, one instance per lane.
- Acquired by the issue side when a DIV/SQRT op issues.
- Receives operands from the FP execution stage on `Req`, computes over a fixed multi-cycle latency, then holds the result.
- The replayed op picks the result up (`Finished`), and the execution stage frees the unit with `Release`.
- Provides the result and IEEE flags that the FP execution stage muxes onto its final-stage `dataOut`/`fflagsOut`.

## Interface
- `DATA_WIDTH`, 32, operand/result width; only 32 (IEEE binary32) is supported.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `Acquire` in 1: issue side claims the unit for a DIV/SQRT op; honoured only in FREE.
- `Flush` in 1: owning op was squashed by recovery; abort from any state.
- `Req` in 1: start request. Operands are valid this cycle.
- `dataInA` in 32: dividend / radicand.
- `dataInB` in 32: divisor; ignored for sqrt.
- `is_divide` in 1: 1 = divide, 0 = sqrt.
- `rm` in 3: resolved rounding mode. 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 treated as RNE.
- `Release` in 1: result consumed; return to FREE.
- `Reserved` out 1: unit is owned (RESERVED state).
- `Busy` out 1: unit not FREE; the issue queue must not issue DIV/SQRT.
- `Finished` out 1: result valid (DONE state).
- `DataOut` out 32: result, stable while `Finished`.
- `FFlagsOut` out 5: {NV,DZ,OF,UF,NX}, stable while `Finished`.

## Operation
- States: FREE, RESERVED, PREP, ITER, ROUND, DONE.
- FREE → RESERVED on `Acquire`.
- RESERVED → PREP on `Req`. Operands, `is_divide` and `rm` are latched at this point; later input changes are ignored.
- PREP (1 cycle):
  - Unpack the operands.
  - Normalise subnormal significands by leading-zero count, adjusting the exponent.
  - Classify specials.
  - Compute the result exponent: (eA−eB+127) for divide; (eA−127)>>1 plus bias for sqrt, pre-shifting the significand when the unbiased exponent is odd.
- ITER: radix-2 restoring recurrence, 26 cycles, 1 result bit per cycle. 5-bit iteration counter runs 0..25. Produces 24 significand bits plus guard and round; sticky = remainder ≠ 0.
- ROUND (1 cycle):
  - Normalise; a divide quotient below 1.0 shifts left 1 and decrements the exponent.
  - Denormalise if the exponent is ≤ 0 (shift right, OR shifted-out bits into sticky).
  - Round per `rm`; a carry-out renormalises.
  - Overflow gives ±inf (RNE/RMM/directed-toward) or ±max-finite, with OF|NX.
  - UF is set when the result is tiny after rounding and inexact.
- Specials (resolved in PREP, carried through the pipeline unchanged):
  - Any sNaN → NV.
  - 0/0 and inf/inf → canonical NaN 0x7fc00000, NV.
  - x/0 with x finite nonzero → ±inf, DZ.
  - sqrt(neg nonzero) → 0x7fc00000, NV.
  - sqrt(−0) → −0.
  - NaN in → 0x7fc00000.
- DONE: hold `DataOut`/`FFlagsOut`; `Finished`=1. On `Release` → FREE.
- `Flush` in any non-FREE state → FREE next cycle. Partial results are discarded and `Finished` drops.
- `Release` outside DONE, `Req` outside RESERVED, and `Acquire` outside FREE are ignored.
- Simultaneous events: `Flush` wins over all other inputs. `Release` together with `Acquire` in DONE → FREE only; `Acquire` is honoured the following cycle.

## Timing
- Reset: state FREE; `Reserved`, `Busy`, `Finished` = 0; `DataOut` = 0; `FFlagsOut` = 0.
- Outputs are registered, decoded from state only.
- With `Req` at cycle t: PREP t+1, ITER t+2..t+27, ROUND t+28, `Finished`=1 from t+29 until the cycle after `Release`.
- `Acquire` at t → `Reserved`=1 at t+1.
- Occupancy of one lane is a single op; no pipelining across ops.
- `rst` mid-operation has the same effect as `Flush`.

## Configuration
- `RSD_FP_DIVSQRT_EARLY_OUT_EN` defined: special-operand cases (NaN, inf, zero operand, x/0, negative sqrt) go PREP → DONE, so `Finished` appears at t+2.
- Undefined: every op takes the full 29-cycle path. Specials are forced through ITER/ROUND unchanged, giving fixed latency.

## Test plan
- Acquire, Req, 1.0/3.0 (0x3f800000, 0x40400000), RNE → `Finished` at t+29, `DataOut` 0x3eaaaaab, `FFlagsOut` 0x01. Release → FREE next cycle.
- sqrt 2.0 (0x40000000), RNE → 0x3fb504f3, flags 0x01. sqrt 4.0 → 0x40000000, flags 0x00.
- 1.0/0.0 → 0x7f800000, flags 0x08. sqrt(−1.0) (0xbf800000) → 0x7fc00000, flags 0x10. Finished at t+2 with the macro, t+29 without.
- 6.0/2.0, RTZ → 0x40400000, flags 0x00. 0x00800000/0x40000000, RNE → 0x00400000 (subnormal), flags 0x00.
- Flush at ITER cycle 10 → FREE next cycle, `Finished` never rises. Acquire+Req then runs a fresh op with correct latency.
- Hold DONE 20 cycles without Release → outputs stable. Acquire asserted during DONE is ignored; Release+Acquire together → FREE, then Reserved one cycle after the next Acquire.

Source files
------------

// File: rtl/fp_div_sqrt_lane.sv
// fp_div_sqrt_lane: iterative IEEE binary32 divide / square-root unit for one FP issue lane.
//   Flow: FREE -> RESERVED (Acquire) -> PREP (Req) -> ITER x26 -> ROUND -> DONE -> FREE (Release).
//   Flush (or rst) aborts from any state. Results are held in DONE until Release.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Acquire, Flush        claim the unit / abort the owning op
//   Req, dataInA/B        start request with dividend|radicand and divisor
//   is_divide, rm         1 = divide, 0 = sqrt; rounding mode (0 RNE,1 RTZ,2 RDN,3 RUP,4 RMM)
//   Release               result consumed
//   Reserved, Busy        unit owned (RESERVED) / unit not FREE
//   Finished              result valid (DONE)
//   DataOut, FFlagsOut    result and {NV,DZ,OF,UF,NX}
// Build option: RSD_FP_DIVSQRT_EARLY_OUT_EN lets special operands skip ITER/ROUND (PREP -> DONE).
module fp_div_sqrt_lane #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Acquire,
    input  logic                  Flush,
    input  logic                  Req,
    input  logic [DATA_WIDTH-1:0] dataInA,
    input  logic [DATA_WIDTH-1:0] dataInB,
    input  logic                  is_divide,
    input  logic [2:0]            rm,
    input  logic                  Release,
    output logic                  Reserved,
    output logic                  Busy,
    output logic                  Finished,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic [4:0]            FFlagsOut
);

    localparam int unsigned SIG_W = 24;
    localparam int unsigned Q_W   = 26;
    localparam int unsigned REM_W = 30;
    localparam int unsigned RAD_W = 52;
    localparam int unsigned EXP_W = 10;
    localparam logic [4:0]  ITER_LAST = 5'd25;
    localparam logic [31:0] QNAN = 32'h7fc0_0000;

    typedef enum logic [2:0] {
        S_FREE, S_RESERVED, S_PREP, S_ITER, S_ROUND, S_DONE
    } state_t;

    state_t state, state_next;

    // Latched request
    logic [31:0] lat_a, lat_b;
    logic        lat_div;
    logic [2:0]  lat_rm;

    // Recurrence state
    logic [REM_W-1:0]        rem;
    logic [Q_W-1:0]          root;
    logic [RAD_W-1:0]        rad;
    logic [SIG_W-1:0]        divisor;
    logic [4:0]              iter_cnt;
    logic signed [EXP_W-1:0] exp_r;
    logic                    sign_r;
    logic                    spec_r;
    logic [31:0]             spec_val_r;
    logic [4:0]              spec_fl_r;

    // Leading-zero count of a 24-bit significand (24 when zero)
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // ---------------- PREP: unpack, normalise, classify ----------------
    logic                    a_sign, b_sign, r_sign;
    logic [7:0]              a_e, b_e;
    logic [22:0]             a_m, b_m;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [23:0]             a_v, b_v, a_sig, b_sig;
    logic [4:0]              a_lz, b_lz;
    logic signed [EXP_W-1:0] a_exp, b_exp, div_exp, sq_ue, sq_exp;
    logic [24:0]             sq_x;
    logic                    prep_spec;
    logic [31:0]             prep_val;
    logic [4:0]              prep_fl;

    always_comb begin
        {a_sign, a_e, a_m} = lat_a;
        {b_sign, b_e, b_m} = lat_b;
        a_zero = (a_e == 8'd0)   && (a_m == 23'd0);
        b_zero = (b_e == 8'd0)   && (b_m == 23'd0);
        a_inf  = (a_e == 8'hff)  && (a_m == 23'd0);
        b_inf  = (b_e == 8'hff)  && (b_m == 23'd0);
        a_nan  = (a_e == 8'hff)  && (a_m != 23'd0);
        b_nan  = (b_e == 8'hff)  && (b_m != 23'd0);
        a_snan = a_nan && !a_m[22];
        b_snan = b_nan && !b_m[22];
        r_sign = lat_div ? (a_sign ^ b_sign) : a_sign;

        // Subnormals: shift the leading one up to bit 23 and pull the exponent down to match
        a_v   = {(a_e != 8'd0), a_m};
        b_v   = {(b_e != 8'd0), b_m};
        a_lz  = lzc24(a_v);
        b_lz  = lzc24(b_v);
        a_sig = a_v << a_lz;
        b_sig = b_v << b_lz;
        a_exp = $signed({2'b00, (a_e == 8'd0) ? 8'd1 : a_e}) - $signed({5'd0, a_lz});
        b_exp = $signed({2'b00, (b_e == 8'd0) ? 8'd1 : b_e}) - $signed({5'd0, b_lz});

        div_exp = a_exp - b_exp + 10'sd127;
        // Odd unbiased exponent: radicand doubled so the halved exponent stays integral
        sq_ue  = a_exp - 10'sd127;
        sq_exp = (sq_ue >>> 1) + 10'sd127;
        sq_x   = sq_ue[0] ? {a_sig, 1'b0} : {1'b0, a_sig};

        prep_spec = 1'b0;
        prep_val  = 32'd0;
        prep_fl   = 5'd0;
        if (lat_div) begin
            if (a_nan || b_nan) begin
                prep_spec = 1'b1; prep_val = QNAN; prep_fl[4] = a_snan | b_snan;
            end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                prep_spec = 1'b1; prep_val = QNAN; prep_fl[4] = 1'b1;
            end else if (a_inf) begin
                prep_spec = 1'b1; prep_val = {r_sign, 8'hff, 23'd0};
            end else if (b_zero) begin
                prep_spec = 1'b1; prep_val = {r_sign, 8'hff, 23'd0}; prep_fl[3] = 1'b1;
            end else if (a_zero || b_inf) begin
                prep_spec = 1'b1; prep_val = {r_sign, 31'd0};
            end
        end else begin
            if (a_nan) begin
                prep_spec = 1'b1; prep_val = QNAN; prep_fl[4] = a_snan;
            end else if (a_zero) begin
                prep_spec = 1'b1; prep_val = {a_sign, 31'd0};
            end else if (a_sign) begin
                prep_spec = 1'b1; prep_val = QNAN; prep_fl[4] = 1'b1;
            end else if (a_inf) begin
                prep_spec = 1'b1; prep_val = 32'h7f80_0000;
            end
        end
    end

    // ---------------- ITER: one restoring step per cycle ----------------
    logic             div_ge, sq_ge, step_bit;
    logic [REM_W-1:0] div_rem_n, sq_rem4, sq_trial, sq_rem_n;

    always_comb begin
        div_ge    = rem >= REM_W'(divisor);
        div_rem_n = (div_ge ? rem - REM_W'(divisor) : rem) << 1;
        sq_rem4   = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
        sq_trial  = REM_W'({root, 2'b01});
        sq_ge     = sq_rem4 >= sq_trial;
        sq_rem_n  = sq_ge ? sq_rem4 - sq_trial : sq_rem4;
        step_bit  = lat_div ? div_ge : sq_ge;
    end

    // ---------------- ROUND: normalise, denormalise, round, pack ----------------
    logic                    norm_shift, r_guard, r_sticky, d_g, d_s, lost, inexact, inc, ovf, ovf_inf;
    logic [SIG_W-1:0]        r_sig;
    logic signed [EXP_W-1:0] n_exp;
    logic [EXP_W-1:0]        sh;
    logic [25:0]             w, w_sh;
    logic [7:0]              exp_base;
    logic [30:0]             packed_r;
    logic [31:0]             rnd_val;
    logic [4:0]              rnd_fl;

    always_comb begin
        // Divide quotient below 1.0 carries one fewer integer bit
        norm_shift = lat_div && !root[Q_W-1];
        r_sig      = norm_shift ? root[24:1] : root[25:2];
        r_guard    = norm_shift ? root[0] : root[1];
        r_sticky   = (norm_shift ? 1'b0 : root[0]) | (rem != '0);
        n_exp      = norm_shift ? exp_r - 10'sd1 : exp_r;

        w        = {r_sig, r_guard, r_sticky};
        sh       = '0;
        w_sh     = w;
        lost     = 1'b0;
        exp_base = 8'(n_exp - 10'sd1);
        if (n_exp <= 10'sd0) begin
            sh       = 10'(10'sd1 - n_exp);
            exp_base = 8'd0;
            if (sh >= 10'd26) begin
                w_sh = '0;
                lost = |w;
            end else begin
                w_sh = w >> sh;
                lost = |(w & ~({26{1'b1}} << sh));
            end
        end
        d_g     = w_sh[1];
        d_s     = w_sh[0] | lost;
        inexact = d_g | d_s;

        case (lat_rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = inexact & sign_r;
            3'd3:    inc = inexact & ~sign_r;
            3'd4:    inc = d_g;
            default: inc = d_g & (d_s | w_sh[2]);
        endcase
        case (lat_rm)
            3'd1:    ovf_inf = 1'b0;
            3'd2:    ovf_inf = sign_r;
            3'd3:    ovf_inf = ~sign_r;
            default: ovf_inf = 1'b1;
        endcase

        // Hidden bit adds into the exponent field, so a rounding carry renormalises for free
        packed_r = {exp_base, 23'd0} + {7'd0, w_sh[25:2]} + 31'(inc);
        ovf      = (n_exp >= 10'sd255) || (packed_r[30:23] == 8'hff);

        if (spec_r) begin
            rnd_val = spec_val_r;
            rnd_fl  = spec_fl_r;
        end else if (ovf) begin
            rnd_val = ovf_inf ? {sign_r, 8'hff, 23'd0} : {sign_r, 8'hfe, 23'h7f_ffff};
            rnd_fl  = 5'b00101;
        end else begin
            rnd_val = {sign_r, packed_r};
            rnd_fl  = {3'b000, inexact && (packed_r[30:23] == 8'd0), inexact};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_FREE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = S_FREE;
        end else begin
            case (state)
                S_FREE:     if (Acquire) state_next = S_RESERVED;
                S_RESERVED: if (Req)     state_next = S_PREP;
`ifdef RSD_FP_DIVSQRT_EARLY_OUT_EN
                S_PREP:     state_next = prep_spec ? S_DONE : S_ITER;
`else
                S_PREP:     state_next = S_ITER;
`endif
                S_ITER:     if (iter_cnt == ITER_LAST) state_next = S_ROUND;
                S_ROUND:    state_next = S_DONE;
                S_DONE:     if (Release) state_next = S_FREE;
                default:    state_next = S_FREE;
            endcase
        end
    end

    // ---------------- Datapath and registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            Reserved   <= 1'b0;
            Busy       <= 1'b0;
            Finished   <= 1'b0;
            DataOut    <= '0;
            FFlagsOut  <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_div    <= 1'b0;
            lat_rm     <= '0;
            rem        <= '0;
            root       <= '0;
            rad        <= '0;
            divisor    <= '0;
            iter_cnt   <= '0;
            exp_r      <= '0;
            sign_r     <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
            spec_fl_r  <= '0;
        end else begin
            Reserved <= (state_next == S_RESERVED);
            Busy     <= (state_next != S_FREE);
            Finished <= (state_next == S_DONE);

            case (state)
                S_RESERVED: begin
                    if (Req) begin
                        lat_a   <= 32'(dataInA);
                        lat_b   <= 32'(dataInB);
                        lat_div <= is_divide;
                        lat_rm  <= rm;
                    end
                end
                S_PREP: begin
                    rem        <= lat_div ? REM_W'(a_sig) : '0;
                    root       <= '0;
                    rad        <= {sq_x, 27'd0};
                    divisor    <= b_sig;
                    iter_cnt   <= 5'd0;
                    exp_r      <= lat_div ? div_exp : sq_exp;
                    sign_r     <= r_sign;
                    spec_r     <= prep_spec;
                    spec_val_r <= prep_val;
                    spec_fl_r  <= prep_fl;
                end
                S_ITER: begin
                    rem      <= lat_div ? div_rem_n : sq_rem_n;
                    root     <= {root[Q_W-2:0], step_bit};
                    rad      <= rad << 2;
                    iter_cnt <= iter_cnt + 5'd1;
                end
                default: ;
            endcase

            if (state_next == S_DONE && state != S_DONE) begin
                if (state == S_PREP) begin
                    DataOut   <= DATA_WIDTH'(prep_val);
                    FFlagsOut <= prep_fl;
                end else begin
                    DataOut   <= DATA_WIDTH'(rnd_val);
                    FFlagsOut <= rnd_fl;
                end
            end
        end
    end

endmodule
